// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I writeback stage: FSM states,
// load funct3 encodings and the default datapath width.
package wb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_if.sv
// Bundle of execute handshake, load-response, register-file write and hazard
// signals around the writeback stage; slave is the stage, master its neighbours.
interface wb_if #(
    parameter int XLEN = wb_pkg::XLEN_DEF
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_load;
    logic [2:0]      ex_funct3;
    logic [1:0]      ex_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pending;
    logic [4:0]      pending_rd;
    logic            err;

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        input  mem_rvalid, mem_rdata,
        output ex_ready, rf_we, rf_waddr, rf_wdata, pending, pending_rd, err
    );

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        output mem_rvalid, mem_rdata,
        input  ex_ready, rf_we, rf_waddr, rf_wdata, pending, pending_rd, err
    );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/half lane of a raw memory
// word and sign- or zero-extends it according to the load funct3.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection; a misaligned halfword only looks at addr_lo[1]
    always_comb begin
        byte_s = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Extension; reserved encodings fall through to a full-word load
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: retires one instruction per transfer into the register
// file, waiting for load data when needed. WB_TIMEOUT_EN adds a load watchdog.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic resetn,
    wb_if.slave bus
);

    wb_state_e       state_q, state_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lo_q, lo_d;
    logic            err_q, err_d;
    logic            xfer_s;
    logic [XLEN-1:0] aligned_s;

`ifdef WB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

    assign xfer_s         = bus.ex_valid && (state_q != WAIT_MEM);
    assign bus.ex_ready   = (state_q != WAIT_MEM);
    assign bus.pending    = (state_q != IDLE);
    assign bus.pending_rd = rd_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.err        = err_q;

    load_align #(.XLEN(XLEN)) u_align (
        .rdata_i   (bus.mem_rdata),
        .funct3_i  (f3_q),
        .addr_lo_i (lo_q),
        .data_o    (aligned_s)
    );

    // Next-state and write-port decode
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        err_d      = err_q;
`ifdef WB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE, WRITE: begin
                if (xfer_s) begin
                    rd_d = bus.ex_rd;
                    if (bus.ex_is_load) begin
                        f3_d    = bus.ex_funct3;
                        lo_d    = bus.ex_addr_lo;
                        state_d = WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = {CW{1'b0}};
`endif
                    end else begin
                        rf_waddr_d = bus.ex_rd;
                        rf_wdata_d = bus.ex_result;
                        rf_we_d    = (bus.ex_rd != 5'd0);
                        state_d    = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                // Load data beats a simultaneous watchdog expiry
                if (bus.mem_rvalid) begin
                    rf_waddr_d = rd_q;
                    rf_wdata_d = aligned_s;
                    rf_we_d    = (rd_q != 5'd0);
                    state_d    = WRITE;
`ifdef WB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    state_d = WAIT_MEM;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= {XLEN{1'b0}};
            rd_q       <= 5'd0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            err_q      <= err_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Load watchdog counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: expected register-file
// writes are queued at stimulus time and checked as the DUT writes.
module tb_writeback_stage;
    import wb_pkg::*;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic resetn;
    int   vectors     = 0;
    int   miscompares = 0;
    wr_t  sb_q[$];

    wb_if #(.XLEN(32)) bus ();

    writeback_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every observed write must match the oldest queued expectation
    always @(negedge clk) begin
        wr_t e;
        if (resetn && bus.rf_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_we", 32'(bus.rf_we), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_waddr", 32'(bus.rf_waddr), 32'(e.a));
                check("sb_wdata", bus.rf_wdata, e.d);
            end
        end
    end

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] rdata, input logic [31:0] exp);
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = rd;
        bus.ex_funct3  = f3;
        bus.ex_addr_lo = lo;
        bus.ex_result  = 32'hA5A5_A5A5;
        step();
        bus.ex_valid   = 1'b0;
        bus.ex_is_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ld_ready", 32'(bus.ex_ready), 32'd0);
            check("ld_pending", 32'(bus.pending), 32'd1);
            if (i < 2) step();
        end
        check("ld_pending_rd", 32'(bus.pending_rd), 32'(rd));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        if (rd != 5'd0) sb_q.push_back(wr_t'{a: rd, d: exp});
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        check("ld_we", 32'(bus.rf_we), 32'(rd != 5'd0));
        check("ld_data", bus.rf_wdata, exp);
        step();
        check("ld_done", 32'(bus.pending), 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.ex_rd      = 5'd0;
        bus.ex_result  = 32'd0;
        bus.ex_is_load = 1'b0;
        bus.ex_funct3  = 3'd0;
        bus.ex_addr_lo = 2'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        step();
        step();
        resetn = 1'b1;
        check("rst_we", 32'(bus.rf_we), 32'd0);
        check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_pending_rd", 32'(bus.pending_rd), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ready", 32'(bus.ex_ready), 32'd1);

        // Single ALU write, latency one cycle
        bus.ex_valid  = 1'b1;
        bus.ex_rd     = 5'd5;
        bus.ex_result = 32'h1234_5678;
        sb_q.push_back(wr_t'{a: 5'd5, d: 32'h1234_5678});
        step();
        bus.ex_valid = 1'b0;
        check("alu_we", 32'(bus.rf_we), 32'd1);
        check("alu_waddr", 32'(bus.rf_waddr), 32'd5);
        check("alu_wdata", bus.rf_wdata, 32'h1234_5678);
        step();
        check("alu_we_off", 32'(bus.rf_we), 32'd0);
        check("alu_hold_addr", 32'(bus.rf_waddr), 32'd5);
        check("alu_hold_data", bus.rf_wdata, 32'h1234_5678);

        // Back-to-back ALU writes
        bus.ex_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.ex_rd     = 5'(i);
            bus.ex_result = 32'h1000_0000 + 32'(i);
            sb_q.push_back(wr_t'{a: 5'(i), d: 32'h1000_0000 + 32'(i)});
            step();
            check("b2b_ready", 32'(bus.ex_ready), 32'd1);
            check("b2b_we", 32'(bus.rf_we), 32'd1);
            check("b2b_waddr", 32'(bus.rf_waddr), 32'(i));
        end
        bus.ex_valid = 1'b0;
        step();
        check("b2b_end", 32'(bus.rf_we), 32'd0);

        // Loads with alignment and extension
        do_load(5'd7,  F3_LB,  2'd2, 32'h0080_0000, 32'hFFFF_FF80);
        do_load(5'd8,  F3_LBU, 2'd2, 32'h0080_0000, 32'h0000_0080);
        do_load(5'd9,  F3_LH,  2'd2, 32'h8001_0000, 32'hFFFF_8001);
        do_load(5'd10, F3_LHU, 2'd2, 32'h8001_0000, 32'h0000_8001);
        do_load(5'd11, F3_LW,  2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load(5'd12, F3_LB,  2'd0, 32'h0000_007F, 32'h0000_007F);
        do_load(5'd13, F3_LB,  2'd3, 32'h8500_0000, 32'hFFFF_FF85);
        do_load(5'd14, 3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        do_load(5'd15, F3_LH,  2'd1, 32'h1234_ABCD, 32'hFFFF_ABCD);
        do_load(5'd16, F3_LHU, 2'd3, 32'hF00D_0000, 32'h0000_F00D);

        // rd = 0 never writes but still passes through WRITE
        bus.ex_valid  = 1'b1;
        bus.ex_rd     = 5'd0;
        bus.ex_result = 32'hFFFF_FFFF;
        step();
        bus.ex_valid = 1'b0;
        check("rd0_we", 32'(bus.rf_we), 32'd0);
        check("rd0_pending", 32'(bus.pending), 32'd1);
        check("rd0_pending_rd", 32'(bus.pending_rd), 32'd0);
        step();
        check("rd0_pending_off", 32'(bus.pending), 32'd0);

        // Stray load response while idle is ignored
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_5555;
        step();
        bus.mem_rvalid = 1'b0;
        check("stray_we", 32'(bus.rf_we), 32'd0);
        check("stray_pending", 32'(bus.pending), 32'd0);

        // Reset while waiting for load data
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd20;
        bus.ex_funct3  = F3_LW;
        step();
        bus.ex_valid   = 1'b0;
        bus.ex_is_load = 1'b0;
        check("rst_wait_ready", 32'(bus.ex_ready), 32'd0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("rst_wait_pending", 32'(bus.pending), 32'd0);
        check("rst_wait_ready2", 32'(bus.ex_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        step();
        bus.mem_rvalid = 1'b0;
        check("rst_wait_we", 32'(bus.rf_we), 32'd0);
        check("rst_wait_pend2", 32'(bus.pending), 32'd0);
        check("rst_wait_waddr", 32'(bus.rf_waddr), 32'd0);

        // Load with no response: watchdog expiry or indefinite wait
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd21;
        bus.ex_funct3  = F3_LW;
        step();
        bus.ex_valid   = 1'b0;
        bus.ex_is_load = 1'b0;
        for (int i = 0; i < 4; i++) step();
`ifdef WB_TIMEOUT_EN
        check("to_err", 32'(bus.err), 32'd1);
        check("to_pending", 32'(bus.pending), 32'd0);
        check("to_we", 32'(bus.rf_we), 32'd0);
`else
        check("nto_err", 32'(bus.err), 32'd0);
        check("nto_pending", 32'(bus.pending), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_F00D;
        sb_q.push_back(wr_t'{a: 5'd21, d: 32'h0BAD_F00D});
        step();
        bus.mem_rvalid = 1'b0;
        check("nto_we", 32'(bus.rf_we), 32'd1);
`endif
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
